// File: rtl/binary_clock_pkg.sv
// Shared types and constants for the binary clock: set-mode states, time field
// widths and wrap-around increment helpers.
package binary_clock_pkg;

  localparam int unsigned HOURS_W          = 5;
  localparam int unsigned MINUTES_W        = 6;
  localparam int unsigned HOURS_PER_DAY    = 24;
  localparam int unsigned MINUTES_PER_HOUR = 60;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_e;

  // Out-of-range values (e.g. a bogus captured 31) also wrap to zero
  function automatic logic [HOURS_W-1:0] next_hour(input logic [HOURS_W-1:0] h);
    return (h >= HOURS_W'(HOURS_PER_DAY - 1)) ? '0 : HOURS_W'(h + HOURS_W'(1));
  endfunction

  function automatic logic [MINUTES_W-1:0] next_minute(input logic [MINUTES_W-1:0] m);
    return (m >= MINUTES_W'(MINUTES_PER_HOUR - 1)) ? '0 : MINUTES_W'(m + MINUTES_W'(1));
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioner: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle press pulse on the level's rising edge.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Level follows the synchronized input only after it has disagreed long enough
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/clock_set_controller.sv
// Time-setting controller: mode/advance buttons walk RUN -> SET_H -> SET_M,
// freezing the clock while editing and issuing a one-cycle load on commit.
module clock_set_controller
  import binary_clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 5,
  parameter int unsigned REPEAT_DELAY    = 50,
  parameter int unsigned REPEAT_RATE     = 10,
  parameter int unsigned TIMEOUT         = 3000,
  parameter int unsigned BLINK_HALF      = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_mode,
  input  logic                 btn_adv,
  input  logic [HOURS_W-1:0]   hours_in,
  input  logic [MINUTES_W-1:0] minutes_in,
  output logic                 hold,
  output logic                 load,
  output logic [HOURS_W-1:0]   hours_out,
  output logic [MINUTES_W-1:0] minutes_out,
  output logic                 blank_h,
  output logic                 blank_m,
  output logic [1:0]           mode
);

  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);

  logic mode_press, adv_press, adv_level;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_mode),
    .level_o (),
    .press_o (mode_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_adv_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_adv),
    .level_o (adv_level),
    .press_o (adv_press)
  );

  state_e               state_q, state_d;
  logic [HOURS_W-1:0]   edit_h_q, edit_h_d;
  logic [MINUTES_W-1:0] edit_m_q, edit_m_d;
  logic                 hold_q, hold_d;
  logic                 load_q, load_d;
  logic                 blank_h_q, blank_h_d;
  logic                 blank_m_q, blank_m_d;
  logic                 phase_q, phase_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic [REP_W-1:0]     rep_cnt_q, rep_cnt_d;
  logic                 rep_armed_q, rep_armed_d;
  logic                 rep_first_q, rep_first_d;

  logic rep_tick_c, adv_event_c, timeout_c, entering_c;

  always_comb begin
    state_d     = state_q;
    edit_h_d    = edit_h_q;
    edit_m_d    = edit_m_q;
    load_d      = 1'b0;
    idle_d      = '0;
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_first_d = rep_first_q;
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q;

    // Counter measures cycles since the press (first tick) or since the last tick
    rep_tick_c = adv_level && rep_armed_q &&
                 (rep_cnt_q == (rep_first_q ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE)));
    if (adv_press) begin
      rep_armed_d = 1'b1;
      rep_first_d = 1'b1;
      rep_cnt_d   = REP_W'(1);
    end else if (!adv_level) begin
      rep_armed_d = 1'b0;
      rep_first_d = 1'b1;
      rep_cnt_d   = '0;
    end else if (rep_tick_c) begin
      rep_first_d = 1'b0;
      rep_cnt_d   = REP_W'(1);
    end else if (rep_armed_q) begin
      rep_cnt_d   = REP_W'(rep_cnt_q + REP_W'(1));
    end

    adv_event_c = adv_press | rep_tick_c;
    timeout_c   = (idle_q == IDLE_W'(TIMEOUT - 1));

    // Mode press takes priority; a simultaneous advance is dropped
    unique case (state_q)
      RUN: begin
        if (mode_press) begin
          state_d  = SET_H;
          edit_h_d = hours_in;
          edit_m_d = minutes_in;
        end
      end
      SET_H: begin
        if (mode_press) begin
          state_d = SET_M;
        end else if (adv_event_c) begin
          edit_h_d = next_hour(edit_h_q);
        end else if (timeout_c) begin
          state_d = RUN;
        end else begin
          idle_d = IDLE_W'(idle_q + IDLE_W'(1));
        end
      end
      SET_M: begin
        if (mode_press) begin
          state_d = RUN;
          load_d  = 1'b1;
        end else if (adv_event_c) begin
          edit_m_d = next_minute(edit_m_q);
        end else if (timeout_c) begin
          state_d = RUN;
        end else begin
          idle_d = IDLE_W'(idle_q + IDLE_W'(1));
        end
      end
      default: state_d = RUN;
    endcase

    entering_c = (state_d != state_q) && (state_d != RUN);
    if (entering_c) begin
      phase_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
      phase_d     = ~phase_q;
      blink_cnt_d = '0;
    end else begin
      blink_cnt_d = BLINK_W'(blink_cnt_q + BLINK_W'(1));
    end

    hold_d    = (state_d != RUN);
    blank_h_d = (state_d == SET_H) && !phase_d;
    blank_m_d = (state_d == SET_M) && !phase_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      edit_h_q    <= '0;
      edit_m_q    <= '0;
      hold_q      <= 1'b0;
      load_q      <= 1'b0;
      blank_h_q   <= 1'b0;
      blank_m_q   <= 1'b0;
      phase_q     <= 1'b1;
      blink_cnt_q <= '0;
      idle_q      <= '0;
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
      rep_first_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      edit_h_q    <= edit_h_d;
      edit_m_q    <= edit_m_d;
      hold_q      <= hold_d;
      load_q      <= load_d;
      blank_h_q   <= blank_h_d;
      blank_m_q   <= blank_m_d;
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
      idle_q      <= idle_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
      rep_first_q <= rep_first_d;
    end
  end

  assign hold        = hold_q;
  assign load        = load_q;
  assign hours_out   = edit_h_q;
  assign minutes_out = edit_m_q;
  assign blank_h     = blank_h_q;
  assign blank_m     = blank_m_q;
  assign mode        = 2'(state_q);

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller: table of button actions with
// expected outputs, plus hand-timed glitch, blink, timeout, repeat and reset cases.
module tb_clock_set_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_adv;
  logic [4:0] hours_in;
  logic [5:0] minutes_in;
  logic       hold, load, blank_h, blank_m;
  logic [4:0] hours_out;
  logic [5:0] minutes_out;
  logic [1:0] mode;

  clock_set_controller #(
    .DEBOUNCE_CYCLES(3),
    .REPEAT_DELAY   (8),
    .REPEAT_RATE    (2),
    .TIMEOUT        (40),
    .BLINK_HALF     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_adv    (btn_adv),
    .hours_in   (hours_in),
    .minutes_in (minutes_in),
    .hold       (hold),
    .load       (load),
    .hours_out  (hours_out),
    .minutes_out(minutes_out),
    .blank_h    (blank_h),
    .blank_m    (blank_m),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n clock cycles, then settle 1 time unit past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw press for 4 cycles, then release and let the debounced level fall
  task automatic press(input logic m, input logic a);
    btn_mode = m;
    btn_adv  = a;
    cyc(4);
    btn_mode = 1'b0;
    btn_adv  = 1'b0;
    cyc(8);
  endtask

  // Load monitor
  int         load_cnt = 0;
  int         load_hold_hi = 0;
  int         double_load = 0;
  logic       prev_load = 1'b0;
  logic [4:0] first_h = '0;
  logic [5:0] first_m = '0;

  always @(negedge clk) begin
    if (load === 1'b1) begin
      if (load_cnt == 0) begin
        first_h = hours_out;
        first_m = minutes_out;
      end
      load_cnt++;
      if (hold !== 1'b0) load_hold_hi++;
      if (prev_load === 1'b1) double_load++;
    end
    prev_load = load;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  typedef struct {
    logic       m;
    logic       a;
    logic [4:0] hin;
    logic [5:0] mins;
    logic [1:0] e_mode;
    logic       e_hold;
    logic [4:0] e_h;
    logic [5:0] e_m;
    int         e_loads;
  } vec_t;

  function automatic vec_t mk(input int m, input int a, input int hin, input int mins,
                              input int e_mode, input int e_hold, input int e_h,
                              input int e_m, input int e_loads);
    vec_t v;
    v.m       = 1'(m);
    v.a       = 1'(a);
    v.hin     = 5'(hin);
    v.mins    = 6'(mins);
    v.e_mode  = 2'(e_mode);
    v.e_hold  = 1'(e_hold);
    v.e_h     = 5'(e_h);
    v.e_m     = 6'(e_m);
    v.e_loads = e_loads;
    return v;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mode"},    int'(mode), 0);
    check({tag, "_hold"},    int'(hold), 0);
    check({tag, "_load"},    int'(load), 0);
    check({tag, "_hours"},   int'(hours_out), 0);
    check({tag, "_minutes"}, int'(minutes_out), 0);
    check({tag, "_blank_h"}, int'(blank_h), 0);
    check({tag, "_blank_m"}, int'(blank_m), 0);
  endtask

  vec_t vecs[17];

  initial begin
    vecs[0]  = mk(1, 0,  7, 30, 1, 1,  7, 30, 0);
    vecs[1]  = mk(0, 1,  7, 30, 1, 1,  8, 30, 0);
    vecs[2]  = mk(0, 1,  7, 30, 1, 1,  9, 30, 0);
    vecs[3]  = mk(0, 1,  7, 30, 1, 1, 10, 30, 0);
    vecs[4]  = mk(1, 0,  7, 30, 2, 1, 10, 30, 0);
    vecs[5]  = mk(0, 1,  7, 30, 2, 1, 10, 31, 0);
    vecs[6]  = mk(0, 1,  7, 30, 2, 1, 10, 32, 0);
    vecs[7]  = mk(1, 0,  7, 30, 0, 0, 10, 32, 1);
    vecs[8]  = mk(1, 0, 23, 59, 1, 1, 23, 59, 1);
    vecs[9]  = mk(0, 1, 23, 59, 1, 1,  0, 59, 1);
    vecs[10] = mk(1, 0, 23, 59, 2, 1,  0, 59, 1);
    vecs[11] = mk(0, 1, 23, 59, 2, 1,  0,  0, 1);
    vecs[12] = mk(1, 0, 23, 59, 0, 0,  0,  0, 2);
    vecs[13] = mk(1, 0, 31,  0, 1, 1, 31,  0, 2);
    vecs[14] = mk(0, 1, 31,  0, 1, 1,  0,  0, 2);
    vecs[15] = mk(0, 1, 31,  0, 1, 1,  1,  0, 2);
    vecs[16] = mk(1, 1, 31,  0, 2, 1,  1,  0, 2);

    rst        = 1'b1;
    btn_mode   = 1'b0;
    btn_adv    = 1'b0;
    hours_in   = '0;
    minutes_in = '0;
    cyc(2);
    check_outputs_zero("reset");
    rst = 1'b0;
    cyc(2);

    // Glitch shorter than the debounce window
    btn_mode = 1'b1;
    cyc(2);
    btn_mode = 1'b0;
    cyc(10);
    check("glitch_mode", int'(mode), 0);

    // 10-cycle press: pulse in cycle 5, SET_H visible in cycle 6
    hours_in   = 5'd7;
    minutes_in = 6'd30;
    btn_mode   = 1'b1;
    cyc(5);
    check("enter_c5_mode", int'(mode), 0);
    cyc(1);
    check("enter_c6_mode", int'(mode), 1);
    check("enter_c6_hold", int'(hold), 1);
    check("enter_c6_hours", int'(hours_out), 7);
    check("enter_c6_minutes", int'(minutes_out), 30);
    check("enter_c6_blank_h", int'(blank_h), 0);
    cyc(4);
    btn_mode = 1'b0;
    check("blink_c10_blank_h", int'(blank_h), 1);
    check("blink_c10_blank_m", int'(blank_m), 0);
    cyc(10);

    // Timeout: one increment, then 40 idle cycles abandon the edit
    btn_adv = 1'b1;
    cyc(4);
    btn_adv = 1'b0;
    cyc(2);
    check("timeout_incr_hours", int'(hours_out), 8);
    cyc(39);
    check("timeout_before_mode", int'(mode), 1);
    cyc(1);
    check("timeout_after_mode", int'(mode), 0);
    check("timeout_after_hold", int'(hold), 0);
    check("timeout_no_load", load_cnt, 0);

    for (int i = 0; i < 17; i++) begin
      hours_in   = vecs[i].hin;
      minutes_in = vecs[i].mins;
      press(vecs[i].m, vecs[i].a);
      check($sformatf("vec%0d_mode", i),    int'(mode),        int'(vecs[i].e_mode));
      check($sformatf("vec%0d_hold", i),    int'(hold),        int'(vecs[i].e_hold));
      check($sformatf("vec%0d_hours", i),   int'(hours_out),   int'(vecs[i].e_h));
      check($sformatf("vec%0d_minutes", i), int'(minutes_out), int'(vecs[i].e_m));
      check($sformatf("vec%0d_loads", i),   load_cnt,          vecs[i].e_loads);
    end
    check("commit_load_hours", int'(first_h), 10);
    check("commit_load_minutes", int'(first_m), 32);
    check("load_while_hold", load_hold_hi, 0);
    check("load_back_to_back", double_load, 0);

    // Auto-repeat in SET_M from 0: press in cycle 5, ticks at 13,15,...,23
    btn_adv = 1'b1;
    cyc(14);
    check("repeat_c14_minutes", int'(minutes_out), 2);
    cyc(6);
    btn_adv = 1'b0;
    cyc(4);
    check("repeat_c24_minutes", int'(minutes_out), 7);
    cyc(20);
    check("repeat_after_release_minutes", int'(minutes_out), 7);
    check("repeat_after_release_mode", int'(mode), 2);

    // Asynchronous reset mid-edit
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    cyc(2);
    rst = 1'b0;
    cyc(10);
    check("midreset_mode_after", int'(mode), 0);
    check("midreset_no_load", load_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_set_controller.md
# clock_set_controller

Time-setting controller for the binary clock. It turns two raw push-buttons (mode, advance) into a three-state set sequence: run, edit hours, edit minutes. While editing it freezes the time counters and drives a blink mask to the 4x4 LED display. On commit it issues a one-cycle load of the edited hours and minutes into the clock counters.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 5: consecutive stable cycles before a synchronized button level is accepted.
- REPEAT_DELAY, 50: cycles that advance must be held after its press before auto-repeat starts.
- REPEAT_RATE, 10: cycles between auto-repeat increments.
- TIMEOUT, 3000: idle cycles in a set state before the edit is abandoned.
- BLINK_HALF, 25: cycles per blink half-period.

Ports:
- clk  in  1  system tick clock (centisecond rate in the design).
- rst  in  1  reset, asynchronous, active-high.
- btn_mode  in  1  raw mode button, asynchronous, active-high.
- btn_adv  in  1  raw advance button, asynchronous, active-high.
- hours_in  in  5  live hours from the clock counters.
- minutes_in  in  6  live minutes from the clock counters.
- hold  out  1  high in either set state; the clock counters must not advance while it is high.
- load  out  1  one-cycle strobe; the clock loads hours_out and minutes_out and zeroes seconds and centiseconds.
- hours_out  out  5  edited hours, range 0..23.
- minutes_out  out  6  edited minutes, range 0..59.
- blank_h  out  1  blank the hours pixels for this cycle.
- blank_m  out  1  blank the minutes pixels for this cycle.
- mode  out  2  current state encoding: 0 RUN, 1 SET_H, 2 SET_M.

## Operation
- Per button: a 2-flop synchronizer (reset 0), then a debounce counter.
  - The debounced level takes the synchronized level once the two have differed for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreeing cycle clears the counter.
  - A press is the debounced level rising; it produces a one-cycle pulse.
- FSM states and transitions:
  - RUN: mode press -> SET_H. On entry, capture edit_h=hours_in and edit_m=minutes_in.
  - SET_H: advance event -> edit_h = (edit_h >= 23) ? 0 : edit_h+1. Mode press -> SET_M.
  - SET_M: advance event -> edit_m = (edit_m >= 59) ? 0 : edit_m+1. Mode press -> RUN and assert load.
  - SET_H or SET_M idle for TIMEOUT cycles -> RUN with no load. The edit is discarded.
- Advance event:
  - An advance press pulse, or
  - an auto-repeat tick: advance still held REPEAT_DELAY cycles after its press, then every REPEAT_RATE cycles while held.
  - Releasing advance stops repeat and re-arms the delay.
  - Advance events in RUN are ignored.
- The idle counter clears on any press or advance event, and on entry to a set state.
- Mode press and advance event in the same cycle: mode wins, the advance is dropped.
- Blink phase:
  - Toggles every BLINK_HALF cycles; forced to "on" at entry to SET_H and SET_M.
  - blank_h = (state==SET_H) & ~phase.
  - blank_m = (state==SET_M) & ~phase.
- hours_out and minutes_out always equal edit_h and edit_m.
- Reset: state RUN, hold=0, load=0, hours_out=0, minutes_out=0, blank_h=0, blank_m=0, mode=0. All counters are cleared and debounced levels are 0.
  - A button held through reset release registers as a press after debounce.
  - Reset mid-edit abandons the edit with no load.

## Timing
- A raw edge stable from cycle 0 produces its press pulse in cycle 2+DEBOUNCE_CYCLES.
- State, edit registers and hold update on the clock edge after the pulse.
- load is registered. It is high for exactly the cycle in which mode first reads RUN after SET_M, and never two cycles in a row.
- hold falls in the same cycle load rises. The clock consumes load while hold is already low.
- Auto-repeat:
  - First repeat tick: REPEAT_DELAY cycles after the press pulse.
  - Following ticks: every REPEAT_RATE cycles after that.
- Timeout fires on the TIMEOUT-th idle cycle; mode reads 0 on the following cycle.

## Structure
- Shared package binary_clock_pkg holds:
  - the state enum {RUN, SET_H, SET_M};
  - HOURS_PER_DAY=24 and MINUTES_PER_HOUR=60;
  - the field widths for hours (5) and minutes (6).
- Sub-module button_debounce (synchronizer, debounce, level and press outputs; parameter DEBOUNCE_CYCLES) is instantiated twice.
- The FSM, repeat, timeout and blink logic stay in the top level.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=3, REPEAT_DELAY=8, REPEAT_RATE=2, TIMEOUT=40, BLINK_HALF=4.
- Glitch rejection: 2-cycle pulse on btn_mode -> no press, mode stays 0. A 10-cycle pulse -> mode=1 at cycle 6, hold=1, edit_h=hours_in.
- Full set: hours_in=7, minutes_in=30. Sequence: mode, 3x adv, mode, 2x adv, mode -> single load with hours_out=10 and minutes_out=32, hold=0 in the load cycle.
- Wrap: edit_h=23 plus adv -> 0. edit_m=59 plus adv -> 0. Captured hours_in=31 plus adv -> 0.
- Auto-repeat: hold adv for 20 cycles after its press pulse in SET_M from 0 -> minutes_out=7 (1 press + 6 repeats). After release, no further increments.
- Timeout: enter SET_H, increment once, then idle 40 cycles -> mode=0, load never asserted, hold=0.
- Collisions: mode and adv pressed together in SET_H -> SET_M with edit_h unchanged. Assert rst mid-SET_M -> all outputs 0 immediately, no load.
